// File: rtl/pixel_stream_source.sv
// -----------------------------------------------------------------------------
// pixel_stream_source
//
// Reads an 8-bit greyscale frame from a synchronous-read frame memory and
// streams it in raster order. Horizontal blanking beats are inserted between
// lines, and between frames when streaming continuously. This block sits at
// the head of the filter pipeline.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   pulse, begins one frame when idle
//   continuous   in   sampled at the last pixel beat of a frame; 1 = keep going
//   mem_addr     out  frame memory read address
//   mem_rden     out  frame memory read enable
//   mem_data     in   read data, valid one cycle after mem_rden/mem_addr
//   dout         out  pixel value (0 on blanking beats)
//   validout     out  stream beat valid
//   blanking_out out  current beat is a blanking beat
//   busy         out  frame in progress
//   frame_done   out  one-cycle pulse after the final beat of a frame
//
// Timing model: the FSM state and counters describe the beat that will be
// registered onto the outputs at the next edge. While that beat is formed, the
// read for the beat after it is issued, so every pixel address leads its
// output beat by exactly two cycles.
// -----------------------------------------------------------------------------
module pixel_stream_source #(
  parameter int ACTIVE_W = 400,
  parameter int H_BLANK  = 2,
  parameter int V_LINES  = 336,
  parameter int ADDR_W   = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [7:0]        mem_data,
  output logic [7:0]        dout,
  output logic              validout,
  output logic              blanking_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int BW = (H_BLANK  > 1) ? $clog2(H_BLANK)  : 1;
  localparam int LW = (V_LINES  > 1) ? $clog2(V_LINES)  : 1;

  localparam logic [CW-1:0]     COL_LAST  = CW'(ACTIVE_W - 1);
  localparam logic [BW-1:0]     BLK_LAST  = BW'(H_BLANK - 1);
  localparam logic [LW-1:0]     LINE_LAST = LW'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ACTIVE_W * V_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ACTIVE,
    S_BLANK,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic [LW-1:0]     line_q, line_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rden_q, mem_rden_d;
  logic [7:0]        dout_q, dout_d;
  logic              validout_q, validout_d;
  logic              blanking_q, blanking_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  // Next-state and read-issue logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    blk_d        = blk_q;
    line_d       = line_q;
    mem_rden_d   = 1'b0;
    mem_addr_d   = mem_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_ACTIVE;
        col_d   = '0;
        blk_d   = '0;
        line_d  = '0;
      end
      S_ACTIVE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          blk_d = '0;
          if (line_q != LINE_LAST) begin
            state_d = S_BLANK;
            line_d  = line_q + LW'(1);
          end else if (continuous) begin
            // Last pixel of the frame: this is the only point where
            // continuous is looked at.
            state_d = S_BLANK;
            line_d  = '0;
          end else begin
            state_d = S_DONE;
            line_d  = '0;
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_BLANK: begin
        if (blk_q == BLK_LAST) begin
          state_d = S_ACTIVE;
          blk_d   = '0;
          col_d   = '0;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read only when the beat following the one now being entered is a pixel;
    // blanking slots and the end of a frame never issue a read.
    unique case (state_d)
      S_FETCH:  mem_rden_d = 1'b1;
      S_ACTIVE: mem_rden_d = (col_d != COL_LAST);
      S_BLANK:  mem_rden_d = (blk_d == BLK_LAST);
      default:  mem_rden_d = 1'b0;
    endcase

    if (state_d == S_FETCH) begin
      mem_addr_d = '0;
    end else if (mem_rden_d) begin
      mem_addr_d = (mem_addr_q == ADDR_LAST) ? '0 : mem_addr_q + ADDR_W'(1);
    end
  end

  // Output beat is formed from the beat described by the current state.
  always_comb begin
    validout_d   = (state_q == S_ACTIVE) || (state_q == S_BLANK);
    blanking_d   = (state_q == S_BLANK);
    dout_d       = (state_q == S_ACTIVE) ? mem_data : 8'd0;
    frame_done_d = (state_q == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      blk_q        <= '0;
      line_q       <= '0;
      mem_addr_q   <= '0;
      mem_rden_q   <= 1'b0;
      dout_q       <= 8'd0;
      validout_q   <= 1'b0;
      blanking_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      blk_q        <= blk_d;
      line_q       <= line_d;
      mem_addr_q   <= mem_addr_d;
      mem_rden_q   <= mem_rden_d;
      dout_q       <= dout_d;
      validout_q   <= validout_d;
      blanking_q   <= blanking_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_rden     = mem_rden_q;
  assign dout         = dout_q;
  assign validout     = validout_q;
  assign blanking_out = blanking_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_source
//
// Directed bench for pixel_stream_source with a 4x3 frame and two blanking
// beats per line gap. The memory model returns the low byte of the address, so
// the expected pixel value is the expected raster address. Expected beats are
// queued when a frame is launched and popped on every output cycle.
// -----------------------------------------------------------------------------
module tb_pixel_stream_source;

  localparam int W  = 4;
  localparam int HB = 2;
  localparam int V  = 3;
  localparam int AW = 8;
  localparam int FRAME_BEATS = W * V + (V - 1) * HB;

  logic          clock;
  logic          reset;
  logic          start;
  logic          continuous;
  logic [AW-1:0] mem_addr;
  logic          mem_rden;
  logic [7:0]    mem_data;
  logic [7:0]    dout;
  logic          validout;
  logic          blanking_out;
  logic          busy;
  logic          frame_done;

  typedef struct packed {
    logic       blank;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    exp_addr;
  int    errors;
  int    checks;

  pixel_stream_source #(
    .ACTIVE_W(W),
    .H_BLANK (HB),
    .V_LINES (V),
    .ADDR_W  (AW)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .mem_addr    (mem_addr),
    .mem_rden    (mem_rden),
    .mem_data    (mem_data),
    .dout        (dout),
    .validout    (validout),
    .blanking_out(blanking_out),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read frame memory: data is the low byte of the address.
  always @(posedge clock) begin
    if (mem_rden) mem_data <= mem_addr[7:0];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one frame of expected beats; trailing blanks only when continuing.
  task automatic push_frame(input bit cont_after);
    beat_t b;
    for (int l = 0; l < V; l++) begin
      for (int c = 0; c < W; c++) begin
        b.blank = 1'b0;
        b.data  = 8'(exp_addr);
        exp_q.push_back(b);
        exp_addr = (exp_addr == W * V - 1) ? 0 : exp_addr + 1;
      end
      if (l < V - 1 || cont_after) begin
        for (int k = 0; k < HB; k++) begin
          b.blank = 1'b1;
          b.data  = 8'd0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rden"},     mem_rden,     0);
    check({tag, "_valid"},    validout,     0);
    check({tag, "_blank"},    blanking_out, 0);
    check({tag, "_dout"},     dout,         0);
    check({tag, "_busy"},     busy,         0);
    check({tag, "_done"},     frame_done,   0);
  endtask

  // Pulse start at a negedge; check the first read and the two-cycle latency.
  task automatic start_frame();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("e0_rden",  mem_rden, 1);
    check("e0_addr",  mem_addr, 0);
    check("e0_busy",  busy,     1);
    check("e0_valid", validout, 0);
    @(negedge clock);
    check("e1_valid", validout, 0);
    check("e1_addr",  mem_addr, 1);
  endtask

  // Observe n consecutive beats, each of which must be valid and match the
  // scoreboard. start is pulsed after beats pa/pb, continuous drops after drop.
  task automatic collect(input int n, input int pa, input int pb, input int drop);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("beat_valid", validout,   1);
      check("beat_busy",  busy,       1);
      check("beat_done",  frame_done, 0);
      check("q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_dout",  dout,         e.data);
        check("beat_blank", blanking_out, e.blank);
      end
      start = (i == pa || i == pb);
      if (i == drop) continuous = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic finish_frame();
    @(negedge clock);
    check("end_done",  frame_done,   1);
    check("end_busy",  busy,         0);
    check("end_valid", validout,     0);
    check("end_blank", blanking_out, 0);
    @(negedge clock);
    check("post_done", frame_done, 0);
    check("post_rden", mem_rden,   0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    exp_addr   = 0;
    start      = 1'b0;
    continuous = 1'b0;
    reset      = 1'b1;

    // Reset state, then idle with no reads.
    repeat (3) @(negedge clock);
    check_idle("rst");
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_idle("idle");
    end

    // Single frame.
    push_frame(1'b0);
    start_frame();
    collect(FRAME_BEATS, -1, -1, -1);
    finish_frame();

    // start re-pulsed mid-frame has no effect.
    push_frame(1'b0);
    start_frame();
    collect(FRAME_BEATS, 2, 8, -1);
    finish_frame();

    // Continuous: three frames back to back, continuous dropped in the third.
    continuous = 1'b1;
    push_frame(1'b1);
    push_frame(1'b1);
    push_frame(1'b0);
    start_frame();
    collect(3 * FRAME_BEATS + 2 * HB, -1, -1, 2 * (FRAME_BEATS + HB) + 4);
    finish_frame();

    // Reset in the middle of a frame, then a clean restart from address 0.
    push_frame(1'b0);
    start_frame();
    collect(7, -1, -1, -1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_valid", validout, 0);
    check("midrst_busy",  busy,     0);
    check("midrst_rden",  mem_rden, 0);
    reset = 1'b0;
    exp_q.delete();
    exp_addr = 0;
    @(negedge clock);
    push_frame(1'b0);
    start_frame();
    collect(FRAME_BEATS, -1, -1, -1);
    finish_frame();

    check("q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
